// File: rtl/invaders_pkg.sv
// invaders_pkg
//   Constants and types shared by the Space Invaders playfield logic.
//   The grid is 32 columns by 16 rows. Row 0 is the top row and the
//   player sits on the bottom row.
package invaders_pkg;

    localparam int GRID_COLS  = 32;
    localparam int GRID_ROWS  = 16;
    localparam int COL_W      = 5;
    localparam int ROW_W      = 4;
    localparam int PLAYER_ROW = 15;

    // What the bullet does on the next enabled clock edge. The top level
    // decodes this combinationally and then applies it in a single
    // registered block.
    typedef enum logic [1:0] {
        BEV_HOLD   = 2'd0,  // nothing changes
        BEV_KILL   = 2'd1,  // hit or exit: bullet disappears
        BEV_STEP   = 2'd2,  // move up one row
        BEV_LAUNCH = 2'd3   // spawn a new bullet above the player
    } bullet_ev_t;

    // Visible state of the single player bullet.
    typedef struct packed {
        logic             flying;
        logic [COL_W-1:0] x;
        logic [ROW_W-1:0] y;
    } bullet_t;

    localparam bullet_t BULLET_IDLE = '{flying: 1'b0, x: '0, y: '0};

endpackage

// File: rtl/bullet_step_timer.sv
// bullet_step_timer
//   Prescaler that paces bullet movement. While `run` is high and `enable`
//   is high, it counts 0..STEP_DIV-1 and wraps. `step` is high during the
//   last count, which is the cycle on which the bullet moves one row.
//
//   Ports
//     clk     : system clock
//     reset   : synchronous active-high reset; clears the counter
//     clr     : synchronous clear; same effect as reset
//     enable  : game-running qualifier; the counter holds when this is low
//     kill    : bullet terminated by a hit; clears the counter (only while
//               enable is high)
//     run     : bullet is flying; the counter advances only while this is
//               high
//     step    : the counter is at its final count and run is high
module bullet_step_timer #(
    parameter int STEP_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic enable,
    input  logic kill,
    input  logic run,
    output logic step
);

    localparam logic [7:0] LAST = 8'(STEP_DIV - 1);

    logic [7:0] cnt;

    // Decoded from the counter register. The top level needs this in the
    // same cycle to decide between a step and an exit.
    assign step = run && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (enable) begin
            if (kill) begin
                cnt <= '0;
            end else if (run) begin
                if (step) cnt <= '0;
                else      cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/bullet.sv
// bullet
//   Player-bullet controller. A rising edge on `shoot` while no bullet is
//   flying launches a bullet at the player's column, just above the
//   player row. The bullet then climbs one row every STEP_DIV enabled
//   cycles. It is removed by a hit, or when it steps past row 0.
//
//   Ports
//     clk     : system clock
//     reset   : synchronous active-high global reset
//     clr     : synchronous bullet clear (game restart); shoot history kept
//     enable  : game running; all bullet state freezes while this is low
//     hit     : collision report; terminates a flying bullet
//     shoot   : fire button (level); a rising edge requests a launch
//     posH    : player column, sampled at launch
//     flying  : a bullet is active
//     bulletX : bullet column
//     bulletY : bullet row, 0 = top
module bullet
    import invaders_pkg::*;
#(
    parameter int START_ROW = 14,
    parameter int STEP_DIV  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             enable,
    input  logic             hit,
    input  logic             shoot,
    input  logic [COL_W-1:0] posH,
    output logic             flying,
    output logic [COL_W-1:0] bulletX,
    output logic [ROW_W-1:0] bulletY
);

    localparam logic [ROW_W-1:0] START_Y = ROW_W'(START_ROW);

    bullet_t    st;
    bullet_ev_t ev;
    logic       shoot_q;
    logic       rise;
    logic       step;

    assign rise = shoot && !shoot_q;

    bullet_step_timer #(
        .STEP_DIV (STEP_DIV)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr),
        .enable (enable),
        .kill   (st.flying && hit),
        .run    (st.flying),
        .step   (step)
    );

    // Pick the event for this edge. A shoot edge that arrives while the
    // bullet is flying or the game is frozen is dropped here. It is not
    // remembered, because shoot_q keeps tracking `shoot` regardless.
    always_comb begin
        ev = BEV_HOLD;
        if (enable) begin
            if (st.flying) begin
                if (hit)
                    ev = BEV_KILL;
                else if (step)
                    // Check for exit before decrementing, so bulletY never
                    // wraps below 0.
                    ev = (st.y == '0) ? BEV_KILL : BEV_STEP;
            end else if (rise) begin
                ev = BEV_LAUNCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st      <= BULLET_IDLE;
            shoot_q <= 1'b0;
        end else begin
            shoot_q <= shoot;
            if (clr) begin
                st <= BULLET_IDLE;
            end else begin
                unique case (ev)
                    BEV_KILL:   st <= BULLET_IDLE;
                    BEV_STEP:   st.y <= st.y - 1'b1;
                    BEV_LAUNCH: st <= '{flying: 1'b1, x: posH, y: START_Y};
                    default:    ;
                endcase
            end
        end
    end

    assign flying  = st.flying;
    assign bulletX = st.x;
    assign bulletY = st.y;

endmodule

// File: tb/tb_bullet.sv
module tb_bullet;

    localparam int START_ROW = 14;
    localparam int STEP_DIV  = 4;
    localparam int FLIGHT    = (START_ROW + 1) * STEP_DIV;

    logic       clk = 1'b0;
    logic       reset, clr, enable, hit, shoot;
    logic [4:0] posH;
    logic       flying;
    logic [4:0] bulletX;
    logic [3:0] bulletY;

    int total = 0;
    int bad   = 0;

    // Reference model: the bullet is described by its age in enabled cycles.
    // The row and the exit follow from the age by plain arithmetic.
    bit m_fly;
    int m_x;
    int m_age;
    bit m_prev;

    bullet #(.START_ROW(START_ROW), .STEP_DIV(STEP_DIV)) dut (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .enable  (enable),
        .hit     (hit),
        .shoot   (shoot),
        .posH    (posH),
        .flying  (flying),
        .bulletX (bulletX),
        .bulletY (bulletY)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int m_y();
        return m_fly ? (START_ROW - m_age / STEP_DIV) : 0;
    endfunction

    // Apply one cycle of inputs, advance the model by the same edge, and
    // compare all outputs.
    task automatic tick(input bit r, input bit c, input bit e, input bit h,
                        input bit s, input int p);
        bit rise;
        reset = r; clr = c; enable = e; hit = h; shoot = s; posH = 5'(p);
        @(posedge clk);
        #1;
        rise   = s && !m_prev;
        m_prev = r ? 1'b0 : s;
        if (r || c) begin
            m_fly = 0; m_x = 0; m_age = 0;
        end else if (e) begin
            if (m_fly) begin
                if (h) begin
                    m_fly = 0; m_x = 0; m_age = 0;
                end else begin
                    m_age++;
                    if (m_age == FLIGHT) begin
                        m_fly = 0; m_x = 0; m_age = 0;
                    end
                end
            end else if (rise) begin
                m_fly = 1; m_x = p; m_age = 0;
            end
        end
        chk("flying",  int'(flying),  int'(m_fly));
        chk("bulletX", int'(bulletX), m_x);
        chk("bulletY", int'(bulletY), m_y());
    endtask

    initial begin
        bit s;
        int p;
        m_fly = 0; m_x = 0; m_age = 0; m_prev = 0;
        reset = 1; clr = 0; enable = 0; hit = 0; shoot = 1; posH = 0;

        // Reset with shoot held high. The first cycle after release is
        // frozen, so the edge is dropped and shoot_q then holds 1.
        tick(1, 0, 0, 0, 1, 0);
        tick(1, 0, 0, 0, 1, 0);
        chk("reset_flying", int'(flying), 0);
        tick(0, 0, 0, 0, 1, 5);
        repeat (5) tick(0, 0, 1, 0, 1, 5);
        chk("held_no_launch", int'(flying), 0);

        // Launch at column 9, then fly all the way out.
        tick(0, 0, 1, 0, 0, 9);
        tick(0, 0, 1, 0, 1, 9);
        chk("launch_x", int'(bulletX), 9);
        chk("launch_y", int'(bulletY), 14);
        repeat (4) tick(0, 0, 1, 0, 1, 9);
        chk("y_after4", int'(bulletY), 13);
        repeat (4) tick(0, 0, 1, 0, 1, 9);
        chk("y_after8", int'(bulletY), 12);
        repeat (FLIGHT - 9) tick(0, 0, 1, 0, 1, 9);
        chk("before_exit", int'(flying), 1);
        tick(0, 0, 1, 0, 1, 9);
        chk("exit_flying", int'(flying), 0);
        chk("exit_y", int'(bulletY), 0);

        // A hit five cycles after launch. Later hits have no effect.
        tick(0, 0, 1, 0, 0, 3);
        tick(0, 0, 1, 0, 1, 3);
        repeat (4) tick(0, 0, 1, 0, 1, 3);
        tick(0, 0, 1, 1, 1, 3);
        chk("hit_kill", int'(flying), 0);
        repeat (3) tick(0, 0, 1, 1, 0, 3);

        // Rapid fire while flying; then end the bullet and relaunch.
        tick(0, 0, 1, 0, 1, 7);
        tick(0, 0, 1, 0, 0, 11);
        tick(0, 0, 1, 0, 1, 12);
        tick(0, 0, 1, 0, 0, 13);
        tick(0, 0, 1, 0, 1, 14);
        chk("rapid_x", int'(bulletX), 7);
        tick(0, 0, 1, 1, 0, 20);
        tick(0, 0, 1, 0, 1, 20);
        chk("relaunch_x", int'(bulletX), 20);

        // Freeze for 10 cycles, then clear.
        repeat (6) tick(0, 0, 1, 0, 1, 20);
        repeat (10) tick(0, 0, 0, 1, 0, 20);
        chk("frozen_fly", int'(flying), 1);
        tick(0, 1, 1, 0, 1, 20);
        chk("clr_fly", int'(flying), 0);

        // Hit and exit each coincide with a shoot edge: no launch occurs.
        tick(0, 0, 1, 0, 0, 4);
        tick(0, 0, 1, 0, 1, 4);
        tick(0, 0, 1, 0, 0, 4);
        tick(0, 0, 1, 1, 1, 4);
        chk("hit_edge_nolaunch", int'(flying), 0);
        tick(0, 0, 1, 0, 0, 6);
        tick(0, 0, 1, 0, 1, 6);
        repeat (FLIGHT - 2) tick(0, 0, 1, 0, 1, 6);
        tick(0, 0, 1, 0, 0, 6);
        tick(0, 0, 1, 0, 1, 6);
        chk("exit_edge_nolaunch", int'(flying), 0);

        // Randomized traffic.
        s = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) s = !s;
            p = int'($urandom_range(0, 31));
            tick($urandom_range(0, 299) == 0, $urandom_range(0, 149) == 0,
                 $urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0, s, p);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
